// File: rtl/cgra_im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings and
// header field positions inside a stream word.
package cgra_im_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_DATA = 3'd1,
    ST_IMM_LO  = 3'd2,
    ST_IMM_HI  = 3'd3,
    ST_DRAIN   = 3'd4
  } ld_state_e;

  // Header word layout; the start address occupies the low address bits.
  localparam int UNIT_MSB  = 31;
  localparam int UNIT_LSB  = 28;
  localparam int COUNT_MSB = 27;
  localparam int COUNT_LSB = 16;

  localparam int UNIT_W = UNIT_MSB - UNIT_LSB + 1;
  localparam int CNT_W  = COUNT_MSB - COUNT_LSB + 1;

endpackage

// File: rtl/cgra_im_loader_hdr.sv
// Combinational header decoder: splits a header word into its fields and
// classifies the target unit as ID memory, IMM memory or nonexistent.
module cgra_im_loader_hdr
  import cgra_im_loader_pkg::*;
#(
  parameter int AW      = 8,
  parameter int NUM_ID  = 9,
  parameter int NUM_IMM = 3
) (
  input  logic [31:0]       data_i,
  output logic [UNIT_W-1:0] unit_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [AW-1:0]     start_o,
  output logic              is_id_o,
  output logic              is_imm_o,
  output logic              bad_unit_o
);

  // One extra bit so NUM_ID+NUM_IMM == 16 still fits.
  localparam logic [UNIT_W:0] N_ID  = (UNIT_W+1)'(NUM_ID);
  localparam logic [UNIT_W:0] N_ALL = (UNIT_W+1)'(NUM_ID + NUM_IMM);

  logic [UNIT_W:0] unit_x;
  logic            unused_hdr_bits;

  assign unit_o  = data_i[UNIT_MSB:UNIT_LSB];
  assign count_o = data_i[COUNT_MSB:COUNT_LSB];
  assign start_o = data_i[AW-1:0];
  assign unit_x  = {1'b0, unit_o};

  assign is_id_o    = unit_x < N_ID;
  assign bad_unit_o = unit_x >= N_ALL;
  assign is_imm_o   = !is_id_o && !bad_unit_o;

  // Bits between the start address and the count field carry no meaning.
  assign unused_hdr_bits = ^data_i[COUNT_LSB-1:AW];

endmodule

// File: rtl/cgra_im_loader.sv
// Streams instruction words into the CGRA's ID/IMM instruction memories.
// A header word selects a unit, a start address and an instruction count;
// payload beats follow (one per ID instruction, two per IMM instruction).
module cgra_im_loader
  import cgra_im_loader_pkg::*;
#(
  parameter int D_WIDTH           = 32,
  parameter int I_WIDTH           = 12,
  parameter int I_IMM_WIDTH       = 33,
  parameter int IM_MEM_ADDR_WIDTH = 8,
  parameter int NUM_ID            = 9,
  parameter int NUM_IMM           = 3
) (
  input  logic                         iClk,
  input  logic                         iReset_n,
  input  logic                         iValid,
  input  logic [D_WIDTH-1:0]           iData,
  output logic                         oReady,
  output logic [NUM_IMM+NUM_ID-1:0]    oIM_WriteEnable,
  output logic [IM_MEM_ADDR_WIDTH-1:0] oIM_WriteAddress,
  output logic [I_WIDTH-1:0]           oIM_WriteData,
  output logic [I_IMM_WIDTH-1:0]       oIM_WriteData_IMM,
  output logic                         oBusy,
  output logic                         oDone,
  output logic                         oError
);

  localparam int NW   = NUM_ID + NUM_IMM;
  localparam int AW   = IM_MEM_ADDR_WIDTH;
  localparam int HI_W = I_IMM_WIDTH - D_WIDTH;

  localparam logic [NW-1:0]    WE_ONE  = NW'(1);
  localparam logic [AW-1:0]    ADDR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [D_WIDTH-1:0] lo_q, lo_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [NW-1:0]     we_q, we_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [I_WIDTH-1:0] wdata_q, wdata_d;
  logic [I_IMM_WIDTH-1:0] wimm_q, wimm_d;

  logic [UNIT_W-1:0] hdr_unit;
  logic [CNT_W-1:0]  hdr_count;
  logic [AW-1:0]     hdr_start;
  logic              hdr_is_id, hdr_is_imm, hdr_bad;
  logic              beat;

  cgra_im_loader_hdr #(
    .AW     (AW),
    .NUM_ID (NUM_ID),
    .NUM_IMM(NUM_IMM)
  ) u_hdr (
    .data_i    (iData[31:0]),
    .unit_o    (hdr_unit),
    .count_o   (hdr_count),
    .start_o   (hdr_start),
    .is_id_o   (hdr_is_id),
    .is_imm_o  (hdr_is_imm),
    .bad_unit_o(hdr_bad)
  );

  // Always ready outside reset, so the stream never backs up.
  assign oReady = iReset_n;
  assign beat   = iValid && oReady;

  assign oIM_WriteEnable   = we_q;
  assign oIM_WriteAddress  = waddr_q;
  assign oIM_WriteData     = wdata_q;
  assign oIM_WriteData_IMM = wimm_q;
  assign oBusy             = state_q != ST_IDLE;
  assign oDone             = done_q;
  assign oError            = err_q;

  // Next-state and registered-output logic; nothing moves without a beat.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    unit_d  = unit_q;
    lo_d    = lo_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we_d    = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wimm_d  = wimm_q;
    if (beat) begin
      unique case (state_q)
        ST_IDLE: begin
          unit_d = hdr_unit;
          rem_d  = hdr_count;
          addr_d = hdr_start;
          // Every header re-evaluates the flag, so a good one clears it.
          err_d  = hdr_bad;
          if (hdr_count == '0) done_d = 1'b1;
          else if (hdr_bad)    state_d = ST_DRAIN;
          else if (hdr_is_id)  state_d = ST_ID_DATA;
          else if (hdr_is_imm) state_d = ST_IMM_LO;
        end
        ST_ID_DATA: begin
          we_d    = WE_ONE << unit_q;
          waddr_d = addr_q;
          wdata_d = iData[I_WIDTH-1:0];
          addr_d  = addr_q + ADDR_ONE;
          rem_d   = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        ST_IMM_LO: begin
          lo_d    = iData;
          state_d = ST_IMM_HI;
        end
        ST_IMM_HI: begin
          we_d    = WE_ONE << unit_q;
          waddr_d = addr_q;
          wimm_d  = {iData[HI_W-1:0], lo_q};
          addr_d  = addr_q + ADDR_ONE;
          rem_d   = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_IMM_LO;
          end
        end
        ST_DRAIN: begin
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons any block in flight.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      unit_q  <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wimm_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      unit_q  <= unit_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      done_q  <= done_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wimm_q  <= wimm_d;
    end
  end

endmodule

// File: doc/cgra_im_loader.md
CGRA_IM_LOADER -- requirements
Module: cgra_im_loader

Interface
REQ-001 Parameter D_WIDTH, default 32: width of the load-stream word.
REQ-002 Parameter I_WIDTH, default 12: instruction width of an ID instruction memory.
REQ-003 Parameter I_IMM_WIDTH, default 33: instruction width of an IMM instruction memory; range D_WIDTH < I_IMM_WIDTH <= 2*D_WIDTH.
REQ-004 Parameter IM_MEM_ADDR_WIDTH, default 8: instruction-memory address width; maximum 11.
REQ-005 Parameters NUM_ID, default 9, and NUM_IMM, default 3: unit counts; NUM_ID+NUM_IMM <= 16.
REQ-006 iClk  in  1  sole clock; all state changes on its rising edge.
REQ-007 iReset_n  in  1  asynchronous, active-low reset.
REQ-008 iValid  in  1  stream word valid.
REQ-009 iData  in  D_WIDTH  stream word (header or payload).
REQ-010 oReady  out  1  loader accepts iData; a beat transfers when iValid&&oReady.
REQ-011 oIM_WriteEnable  out  NUM_IMM+NUM_ID  one-hot write strobe; bit i<NUM_ID selects ID memory i, bit NUM_ID+k selects IMM memory k.
REQ-012 oIM_WriteAddress  out  IM_MEM_ADDR_WIDTH  shared write address.
REQ-013 oIM_WriteData  out  I_WIDTH  ID write data.
REQ-014 oIM_WriteData_IMM  out  I_IMM_WIDTH  IMM write data.
REQ-015 oBusy  out  1  high whenever state != IDLE; the CGRA holds fetch while high.
REQ-016 oDone  out  1  one-cycle pulse at the end of each block.
REQ-017 oError  out  1  sticky bad-unit flag.

Function
REQ-018 Header word fields: unit = iData[31:28], count = iData[27:16] (0..2^IM_MEM_ADDR_WIDTH), start = iData[IM_MEM_ADDR_WIDTH-1:0]; other bits ignored.
REQ-019 FSM states: IDLE, ID_DATA, IMM_LO, IMM_HI, DRAIN; oReady = 1 in every state.
REQ-020 IDLE, header accepted: count=0 -> stay IDLE, pulse oDone next cycle; unit>=NUM_ID+NUM_IMM -> set oError, enter DRAIN (DRAIN with count=0 exits immediately); unit<NUM_ID -> ID_DATA; otherwise -> IMM_LO.
REQ-021 oError clears on the next accepted header with a valid unit.
REQ-022 ID_DATA: each accepted beat writes iData[I_WIDTH-1:0] to the selected unit.
REQ-023 IMM_LO: latch the beat as bits [D_WIDTH-1:0], go to IMM_HI; IMM_HI: the beat supplies bits [I_IMM_WIDTH-1:D_WIDTH] from iData[I_IMM_WIDTH-D_WIDTH-1:0], issue the write, return to IMM_LO.
REQ-024 DRAIN: consume count beats with no write strobe.
REQ-025 Write latency: strobe, address and data are registered; they appear exactly one cycle after the completing beat; the strobe is high for one cycle per instruction; outputs hold otherwise.
REQ-026 Address starts at start and increments by 1 per write, wrapping modulo 2^IM_MEM_ADDR_WIDTH.
REQ-027 Remaining-instruction counter: 12 bits, decrements per instruction (per beat in DRAIN).
REQ-028 Final instruction: the FSM enters IDLE on the same edge; oDone pulses in the cycle the final strobe is high.
REQ-029 iValid low mid-block stalls the FSM without loss; no timeout.
REQ-030 Throughput is one beat per cycle; a new header is accepted in the cycle immediately after the final beat.

Reset
REQ-031 iReset_n low: state=IDLE; oIM_WriteEnable=0, oIM_WriteAddress=0, oIM_WriteData=0, oIM_WriteData_IMM=0, oDone=0, oError=0, oBusy=0, counters=0.
REQ-032 Reset mid-block abandons the block; no strobe is issued after assertion; the first beat after release is treated as a header.
REQ-033 oReady is 0 while iReset_n is low.

Structure
REQ-034 A shared package/include holds the state encodings and the header field positions (UNIT_MSB/LSB, COUNT_MSB/LSB).
REQ-035 One sub-module, cgra_im_loader_hdr: a combinational header decoder giving unit, count, start, is_id, is_imm and bad_unit.
REQ-036 Outputs connect directly to the instruction-memory write ports: WriteEnable, WriteAddress, WriteData, WriteData_IMM.

Verification
REQ-037 Header unit=2, count=3, start=0x10, then payloads 0xA01, 0xA02, 0xA03 back-to-back -> WE=0x004 for three consecutive cycles at addresses 0x10..0x12 with matching data; oDone pulses with the third strobe.
REQ-038 Header unit=9, count=1, start=0xFF, then beats 0xDEADBEEF, 0x1 -> WE=0x200, address 0xFF, WriteData_IMM=0x1DEADBEEF, one cycle after the second beat.
REQ-039 Header unit=0, count=2, start=0xFF -> writes at 0xFF then 0x00 (wrap).
REQ-040 Header unit=13, count=2, then 2 beats -> oError=1, no strobe; next header unit=1, count=1 clears oError and writes normally.
REQ-041 Header count=0 -> no strobe, oDone pulse, oBusy returns low.
REQ-042 iValid toggling mid-block, then iReset_n low after 1 of 3 beats -> strobes only for accepted beats; after reset all outputs are 0 and the next beat decodes as a header.
